// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: boot wait, sequential fetch into a
// 2-entry {pc,instr} queue, redirect handling and sticky fault reporting.
module imem_fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_BYTES   = 100,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] fetch_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [1:0]  fault,
  output logic        busy
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [1:0] F_NONE  = 2'b00;
  localparam logic [1:0] F_ALIGN = 2'b01;
  localparam logic [1:0] F_RANGE = 2'b10;

  localparam logic [32:0] MEM_LIM = 33'(MEM_BYTES);

  logic [1:0]  state_q, state_d;
  logic [31:0] boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] e0_pc_q, e0_pc_d;
  logic [31:0] e0_ins_q, e0_ins_d;
  logic [31:0] e1_pc_q, e1_pc_d;
  logic [31:0] e1_ins_q, e1_ins_d;

  logic deq_req;
  logic do_deq;
  logic enq;
  logic flush;
  logic pc_ok;
  logic rd_ok;

  // Range checks are done in 33 bits so a pc near 2^32 cannot wrap into range
  assign pc_ok = ({1'b0, pc_q} + 33'd4) <= MEM_LIM;
  assign rd_ok = ({1'b0, redirect_pc} + 33'd4) <= MEM_LIM;

  assign deq_req = (cnt_q != 2'd0) && out_ready;

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    enq        = 1'b0;
    flush      = 1'b0;
    do_deq     = deq_req;
    unique case (state_q)
      S_BOOT: begin
        boot_cnt_d = boot_cnt_q + 32'd1;
        if ((boot_cnt_q + 32'd1) >= BOOT_CYCLES) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        if (redirect) begin
          flush  = 1'b1;
          do_deq = 1'b0;
          if (redirect_pc[1:0] != 2'b00) begin
            fault_d = F_ALIGN;
            state_d = S_HALT;
          end else if (!rd_ok) begin
            fault_d = F_RANGE;
            state_d = S_HALT;
          end else begin
            pc_d    = redirect_pc;
            state_d = S_FETCH;
          end
        end else if (state_q == S_FETCH) begin
          if (!pc_ok) begin
            fault_d = F_RANGE;
            state_d = S_HALT;
          end else if ((cnt_q != 2'd2) || deq_req) begin
            enq  = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
      end
    endcase
  end

  // Entry 0 is always the head; a dequeue shifts entry 1 down
  always_comb begin
    cnt_d    = cnt_q;
    e0_pc_d  = e0_pc_q;
    e0_ins_d = e0_ins_q;
    e1_pc_d  = e1_pc_q;
    e1_ins_d = e1_ins_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else if (enq && !do_deq) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd0) begin
        e0_pc_d  = pc_q;
        e0_ins_d = imem_instr;
      end else begin
        e1_pc_d  = pc_q;
        e1_ins_d = imem_instr;
      end
    end else if (!enq && do_deq) begin
      cnt_d    = cnt_q - 2'd1;
      e0_pc_d  = e1_pc_q;
      e0_ins_d = e1_ins_q;
    end else if (enq && do_deq) begin
      if (cnt_q == 2'd1) begin
        e0_pc_d  = pc_q;
        e0_ins_d = imem_instr;
      end else begin
        e0_pc_d  = e1_pc_q;
        e0_ins_d = e1_ins_q;
        e1_pc_d  = pc_q;
        e1_ins_d = imem_instr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_BOOT;
      boot_cnt_q <= 32'd0;
      pc_q       <= RESET_PC;
      cnt_q      <= 2'd0;
      fault_q    <= F_NONE;
      e0_pc_q    <= 32'd0;
      e0_ins_q   <= 32'd0;
      e1_pc_q    <= 32'd0;
      e1_ins_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      e0_pc_q    <= e0_pc_d;
      e0_ins_q   <= e0_ins_d;
      e1_pc_q    <= e1_pc_d;
      e1_ins_q   <= e1_ins_d;
    end
  end

  assign fetch_pc  = pc_q;
  assign out_valid = cnt_q != 2'd0;
  assign out_pc    = e0_pc_q;
  assign out_instr = e0_ins_q;
  assign fault     = fault_q;
  assign busy      = state_q == S_BOOT;

endmodule

// File: doc/imem_fetch_sequencer.md
IMEM_FETCH_SEQUENCER -- requirements
Module: imem_fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after boot.
REQ-002 SHALL have parameter MEM_BYTES, default 100, instruction memory size in bytes.
REQ-003 SHALL have parameter BOOT_CYCLES, default 2, cycles to wait after reset deasserts, while memory contents load.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port fetch_pc  output  32  byte address driven to the instruction memory pc input.
REQ-007 SHALL have port imem_instr  input  32  combinational instruction word returned for fetch_pc in the same cycle.
REQ-008 SHALL have port redirect  input  1  branch/jump redirect request, one-cycle pulse.
REQ-009 SHALL have port redirect_pc  input  32  redirect target, valid when redirect=1.
REQ-010 SHALL have port out_valid  output  1  queue head holds a valid instruction.
REQ-011 SHALL have port out_ready  input  1  decode accepts the head this cycle.
REQ-012 SHALL have port out_instr  output  32  head instruction word.
REQ-013 SHALL have port out_pc  output  32  head instruction address.
REQ-014 SHALL have port fault  output  2  sticky fault code: 00 none, 01 misaligned target, 10 fetch beyond memory.
REQ-015 SHALL have port busy  output  1  1 when state is BOOT.

Function
REQ-016 SHALL implement states BOOT, FETCH, HALT.
REQ-017 BOOT: count BOOT_CYCLES cycles, no enqueue, fetch_pc=RESET_PC, then move to FETCH; redirect in BOOT is ignored.
REQ-018 SHALL hold a 2-entry FIFO of {pc,instr}; out_valid = (count!=0); head presented combinationally from the storage registers.
REQ-019 Dequeue SHALL occur when out_valid && out_ready.
REQ-020 In FETCH with no redirect, enqueue {fetch_pc, imem_instr} and advance fetch_pc by 4 when count<2, or count==2 with dequeue in the same cycle; otherwise hold fetch_pc (stall).
REQ-021 Enqueue and dequeue in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-022 Fetch-to-out_valid latency SHALL be 1 cycle: a word enqueued at edge N is visible on out_* after edge N.
REQ-023 Redirect (FETCH or HALT) SHALL take priority over all other actions: flush the FIFO (count=0 next cycle), suppress that cycle's enqueue and dequeue, load fetch_pc=redirect_pc.
REQ-024 A redirect with redirect_pc[1:0]!=0 SHALL flush the FIFO, set fault=01, and enter HALT; fetch_pc holds its old value.
REQ-025 In FETCH, if fetch_pc+4 > MEM_BYTES (compared in 33-bit arithmetic), the sequencer SHALL not enqueue, set fault=10, and enter HALT.
REQ-026 A redirect with an aligned target with redirect_pc+4 <= MEM_BYTES SHALL be accepted; the next cycle fetches from it.
REQ-027 A redirect with an aligned target with redirect_pc+4 > MEM_BYTES SHALL flush the FIFO, set fault=10, and enter HALT.
REQ-028 HALT: no enqueue; existing FIFO entries still drain through out_ready; leaves only on an accepted redirect (to FETCH) or reset.
REQ-029 fault SHALL be sticky, cleared only by reset; a later fault overwrites the code.
REQ-030 fetch_pc SHALL wrap modulo 2^32; no other wrap behaviour.

Reset
REQ-031 While reset=1 at an edge: state=BOOT, boot counter=0, count=0, fetch_pc=RESET_PC, fault=00.
REQ-032 After reset: out_valid=0, busy=1, out_instr=0, out_pc=0, and FIFO storage is cleared to 0.
REQ-033 Reset asserted mid-operation SHALL discard queued entries and any pending redirect in the same cycle.

Verification
REQ-034 Reset, BOOT_CYCLES=2, out_ready=1 -> busy=1 for 2 cycles; first out_valid with out_pc=0, then out_pc 4, 8, 12 on consecutive cycles.
REQ-035 out_ready=0 from boot -> FIFO fills with pc 0 and 4, fetch_pc stalls at 8; out_ready=1 for one cycle -> pc 0 dequeued, pc 8 enqueued the same cycle, count stays 2.
REQ-036 FIFO holds pc 16 and 20, redirect_pc=0x40 -> out_valid=0 next cycle, then out_pc=0x40 with out_instr=imem word at 0x40.
REQ-037 redirect_pc=0x22 -> fault=01, HALT, no enqueue; then redirect_pc=0x10 -> FETCH resumes at 0x10, fault stays 01.
REQ-038 MEM_BYTES=100, sequential fetch -> last enqueued pc=0x60, fault=10 when fetch_pc=0x64; queued entries drain normally.
REQ-039 Reset asserted while the FIFO is full and a redirect is pending -> next cycle count=0, fetch_pc=RESET_PC, fault=00, busy=1.
